// File: rtl/axi_dc_pkg.sv
// Shared definitions for the dual-clock AXI slice.
//   idx_w()      : slot-index width for a token-ring buffer of n slots
//   *_chan_t     : packed per-channel payloads; their $bits set the
//                  DATA_WIDTH of each channel instance
package axi_dc_pkg;

  // Slot-index width, kept at least 1 so a 1-deep ring still gets a bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } ar_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  localparam int AW_CHAN_W = $bits(aw_chan_t);
  localparam int AR_CHAN_W = $bits(ar_chan_t);
  localparam int W_CHAN_W  = $bits(w_chan_t);
  localparam int R_CHAN_W  = $bits(r_chan_t);
  localparam int B_CHAN_W  = $bits(b_chan_t);

endpackage

// File: rtl/axi_dc_channel_rx_if.sv
// Local valid/ready/data port of one channel receiver.
//   master : the receiver (drives valid/data, samples ready)
//   slave  : the local consumer
interface axi_dc_channel_rx_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dc_sync_bits.sv
// N-bit multi-flop synchroniser. Each bit is synchronised independently, so
// only use it on signals where each bit changes at most once per handshake.
//   clk_i/rst_i : destination clock, synchronous active-high reset
//   d_i         : asynchronous input bits
//   q_o         : synchronised bits, STAGES edges later
module dc_sync_bits #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  // Shift toward the top; stage 0 is the metastability-catching flop.
  always_comb sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/axi_dc_channel_rx.sv
// Reader end of one token-ring async channel. Synchronises the sender's write
// tokens, pops buffer slots strictly in order into a one-entry output
// register, and hands a toggle-coded read pointer back to the sender.
//   clk_i, rst_i    : local clock, synchronous active-high reset
//   isolate_i       : hide the output and drain the buffer
//   data_async_i    : sender buffer, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   write_token_i   : sender toggle bits (async), bit k = slot k written
//   read_pointer_o  : reader toggle bits, bit k = slot k consumed
//   out_if          : local valid/data/ready port
module axi_dc_channel_rx
  import axi_dc_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_WIDTH = 8,   // >= 2
  parameter int SYNC_STAGES  = 2    // >= 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               isolate_i,
  input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_i,
  input  logic [BUFFER_WIDTH-1:0]            write_token_i,
  output logic [BUFFER_WIDTH-1:0]            read_pointer_o,
  axi_dc_channel_rx_if.master                out_if
);

  localparam int IW = idx_w(BUFFER_WIDTH);

  logic [BUFFER_WIDTH-1:0]                 wt_s;
  logic [BUFFER_WIDTH-1:0][DATA_WIDTH-1:0] slots;

  logic [IW-1:0]           rd_idx_q, rd_idx_d;
  logic [BUFFER_WIDTH-1:0] rp_q, rp_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic eff_ready, full_cur, load;

  dc_sync_bits #(
    .WIDTH  (BUFFER_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_wt_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (write_token_i),
    .q_o   (wt_s)
  );

  assign slots = data_async_i;

  // Isolation acts as a permanent consumer so the sender keeps draining.
  assign eff_ready = out_if.ready | isolate_i;
  // Toggle coding: a slot holds a word while the two toggles disagree.
  assign full_cur  = wt_s[rd_idx_q] ^ rp_q[rd_idx_q];
  assign load      = full_cur & (~out_valid_q | eff_ready);

  always_comb begin
    rd_idx_d    = rd_idx_q;
    rp_d        = rp_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    if (load) begin
      // Slot is only read once its token is synced, so its data is stable.
      data_d           = slots[rd_idx_q];
      rp_d[rd_idx_q]   = ~rp_q[rd_idx_q];
      rd_idx_d         = (rd_idx_q == IW'(BUFFER_WIDTH-1)) ? '0 : rd_idx_q + 1'b1;
      out_valid_d      = 1'b1;
    end else if (eff_ready) begin
      out_valid_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_idx_q    <= '0;
      rp_q        <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      rd_idx_q    <= rd_idx_d;
      rp_q        <= rp_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  assign out_if.valid   = out_valid_q & ~isolate_i;
  assign out_if.data    = data_q;
  assign read_pointer_o = rp_q;

endmodule

// File: tb/tb_axi_dc_channel_rx.sv
module tb_axi_dc_channel_rx;

  localparam int DW = 64;
  localparam int BW = 8;
  localparam int SS = 2;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             isolate_i = 1'b0;
  logic [BW*DW-1:0] data_async = '0;
  logic [BW-1:0]    wt = '0;
  logic [BW-1:0]    read_pointer_o;
  int               wr_idx = 0;

  int n_vec = 0;
  int n_err = 0;

  axi_dc_channel_rx_if #(.DATA_WIDTH(DW)) out_if ();

  axi_dc_channel_rx #(
    .DATA_WIDTH   (DW),
    .BUFFER_WIDTH (BW),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .isolate_i      (isolate_i),
    .data_async_i   (data_async),
    .write_token_i  (wt),
    .read_pointer_o (read_pointer_o),
    .out_if         (out_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, iso, rdy, wr;
    logic [63:0] wval;
    bit          ev;
    logic [63:0] ed;
    logic [7:0]  erp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit rst, bit iso, bit rdy, bit wr, logic [63:0] wv,
                              bit ev, logic [63:0] ed, logic [7:0] erp);
    vec_t v;
    v.rst = rst; v.iso = iso; v.rdy = rdy; v.wr = wr; v.wval = wv;
    v.ev = ev; v.ed = ed; v.erp = erp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Sender model: fill the next slot, then toggle its write token.
  task automatic send(input logic [63:0] val);
    data_async[wr_idx*DW +: DW] = val;
    wt[wr_idx] = ~wt[wr_idx];
    wr_idx = (wr_idx + 1) % BW;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; isolate_i = 1'b0; out_if.ready = 1'b0;
    wt = '0; wr_idx = 0;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    out_if.ready = 1'b0;

    // ---- single word ----
    tv.push_back(mk(1,0,1,0,0,             0,64'h0,0));
    tv.push_back(mk(0,0,1,1,64'hDEADBEEF,  0,64'h0,0));
    tv.push_back(mk(0,0,1,0,0,             0,64'h0,0));
    tv.push_back(mk(0,0,1,0,0,             1,64'hDEADBEEF,8'h01));
    tv.push_back(mk(0,0,1,0,0,             0,64'hDEADBEEF,8'h01));
    // ---- back-pressure ----
    tv.push_back(mk(1,0,0,0,0,             0,64'h0,0));
    tv.push_back(mk(0,0,0,1,64'h1,         0,64'h0,0));
    tv.push_back(mk(0,0,0,1,64'h2,         0,64'h0,0));
    tv.push_back(mk(0,0,0,1,64'h3,         1,64'h1,8'h01));
    tv.push_back(mk(0,0,0,1,64'h4,         1,64'h1,8'h01));
    for (int i = 0; i < 7; i++)
      tv.push_back(mk(0,0,0,0,0,           1,64'h1,8'h01));
    tv.push_back(mk(0,0,1,0,0,             1,64'h2,8'h03));
    tv.push_back(mk(0,0,1,0,0,             1,64'h3,8'h07));
    tv.push_back(mk(0,0,1,0,0,             1,64'h4,8'h0F));
    tv.push_back(mk(0,0,1,0,0,             0,64'h4,8'h0F));
    // ---- isolation ----
    tv.push_back(mk(1,0,0,0,0,             0,64'h0,0));
    tv.push_back(mk(0,1,0,1,64'hA1,        0,64'h0,0));
    tv.push_back(mk(0,1,0,1,64'hA2,        0,64'h0,0));
    tv.push_back(mk(0,1,0,1,64'hA3,        0,64'hA1,8'h01));
    tv.push_back(mk(0,1,0,0,0,             0,64'hA2,8'h03));
    tv.push_back(mk(0,1,0,0,0,             0,64'hA3,8'h07));
    tv.push_back(mk(0,1,0,0,0,             0,64'hA3,8'h07));
    tv.push_back(mk(0,0,0,1,64'h55,        0,64'hA3,8'h07));
    tv.push_back(mk(0,0,0,0,0,             0,64'hA3,8'h07));
    tv.push_back(mk(0,0,0,0,0,             1,64'h55,8'h0F));
    tv.push_back(mk(0,0,0,0,0,             1,64'h55,8'h0F));
    tv.push_back(mk(0,0,1,0,0,             0,64'h55,8'h0F));
    // ---- reset mid-stream ----
    tv.push_back(mk(1,0,0,0,0,             0,64'h0,0));
    tv.push_back(mk(0,0,0,1,64'h10,        0,64'h0,0));
    tv.push_back(mk(0,0,0,1,64'h11,        0,64'h0,0));
    tv.push_back(mk(0,0,0,1,64'h12,        1,64'h10,8'h01));
    tv.push_back(mk(0,0,0,1,64'h13,        1,64'h10,8'h01));
    tv.push_back(mk(0,0,0,1,64'h14,        1,64'h10,8'h01));
    tv.push_back(mk(0,0,1,0,0,             1,64'h11,8'h03));
    tv.push_back(mk(0,0,1,0,0,             1,64'h12,8'h07));
    tv.push_back(mk(1,0,1,0,0,             0,64'h0,8'h00));
    tv.push_back(mk(0,0,1,1,64'h77,        0,64'h0,8'h00));
    tv.push_back(mk(0,0,1,0,0,             0,64'h0,8'h00));
    tv.push_back(mk(0,0,1,0,0,             1,64'h77,8'h01));
    tv.push_back(mk(0,0,1,0,0,             0,64'h77,8'h01));

    foreach (tv[i]) begin
      rst_i = tv[i].rst; isolate_i = tv[i].iso; out_if.ready = tv[i].rdy;
      if (tv[i].rst) begin wt = '0; wr_idx = 0; end
      if (tv[i].wr) send(tv[i].wval);
      tick();
      chk($sformatf("vec%0d_valid", i), {63'b0, out_if.valid}, {63'b0, tv[i].ev});
      chk($sformatf("vec%0d_data", i), out_if.data, tv[i].ed);
      chk($sformatf("vec%0d_rp", i), {56'b0, read_pointer_o}, {56'b0, tv[i].erp});
    end
    rst_i = 1'b0; isolate_i = 1'b0;

    // ---- wrap-around, random ready, 20 words ----
    begin
      logic [63:0] expq[$];
      int          sent = 0, got = 0;
      int          tog[BW];
      logic [BW-1:0] prev_rp;
      bit          stall;
      logic [63:0] pd;
      do_reset();
      foreach (tog[b]) tog[b] = 0;
      prev_rp = read_pointer_o;
      for (int c = 0; c < 2000 && got < 20; c++) begin
        out_if.ready = ($urandom_range(0, 3) != 0);
        if (out_if.valid && out_if.ready) begin
          if (expq.size() == 0) chk("wrap_underflow", 64'd1, 64'd0);
          else chk("wrap_data", out_if.data, expq.pop_front());
          got++;
        end
        if (sent < 20 && wt[wr_idx] == read_pointer_o[wr_idx]) begin
          expq.push_back(64'hC000 + 64'(sent));
          send(64'hC000 + 64'(sent));
          sent++;
        end
        stall = out_if.valid && !out_if.ready;
        pd = out_if.data;
        tick();
        if (stall) begin
          chk("wrap_hold_valid", {63'b0, out_if.valid}, 64'd1);
          chk("wrap_hold_data", out_if.data, pd);
        end
        for (int b = 0; b < BW; b++)
          if (read_pointer_o[b] != prev_rp[b]) tog[b]++;
        prev_rp = read_pointer_o;
      end
      chk("wrap_count", 64'(got), 64'd20);
      for (int b = 0; b < BW; b++)
        chk($sformatf("wrap_tog%0d", b), 64'(tog[b]), (b < 4) ? 64'd3 : 64'd2);
      chk("wrap_rp", {56'b0, read_pointer_o}, 64'h0F);
    end

    // ---- sustained rate ----
    begin
      int first = -1, got = 0, gaps = 0;
      do_reset();
      out_if.ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
        if (c < 16) send(64'h100 + 64'(c));
        tick();
        if (out_if.valid) begin
          if (first < 0) first = c;
          chk("rate_data", out_if.data, 64'h100 + 64'(got));
          got++;
        end else if (first >= 0 && got < 16) begin
          gaps++;
        end
      end
      chk("rate_latency", 64'(first), 64'(SS));
      chk("rate_gaps", 64'(gaps), 64'd0);
      chk("rate_count", 64'(got), 64'd16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
